// File: rtl/serial_comparator_if.sv
// Bit-pair stream into the serial comparator and the result flags out of it.
// The stream source drives through master; the comparator uses slave.
interface serial_comparator_if;
    logic start;
    logic valid;
    logic a;
    logic b;
    logic busy;
    logic done;
    logic g;
    logic l;
    logic e;

    modport master (
        output start, valid, a, b,
        input  busy, done, g, l, e
    );

    modport slave (
        input  start, valid, a, b,
        output busy, done, g, l, e
    );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial WIDTH-bit magnitude comparator.
// Takes one (a, b) bit pair per accepted cycle. A frame opens with start & valid.
// After WIDTH pairs, the registered g/l/e flags update and done pulses for one cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no frame open; waiting for start & valid (that pair is bit 0)
// SHIFT | frame open; r_cnt pairs already accepted, stalls on valid = 0
module serial_comparator #(
    parameter int WIDTH     = 8,    // legal 2..32
    parameter bit MSB_FIRST = 1'b1
) (
    input logic                clk,
    input logic                rst_n,
    serial_comparator_if.slave bus
);

    localparam int              CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        DEC_UND = 2'd0,
        DEC_GT  = 2'd1,
        DEC_LT  = 2'd2
    } dec_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    dec_t            r_dec;
    logic            r_busy;
    logic            r_done;
    logic            r_g;
    logic            r_l;
    logic            r_e;

    logic            w_first;
    logic            w_last;
    dec_t            w_dec_base;
    dec_t            w_dec_next;

    // A start pair opens a new frame in IDLE and restarts the frame in SHIFT.
    assign w_first = bus.valid & bus.start;

    // This pair is the final one of the running frame. A restart on that slot takes priority.
    assign w_last  = bus.valid & ~bus.start & (r_state == SHIFT) & (r_cnt == LAST_IDX);

    // Decision after this pair. A new frame starts from UNDECIDED.
    // MSB-first keeps the first difference it sees.
    // LSB-first lets each later difference override the earlier one, so the most significant one wins.
    always_comb begin
        w_dec_base = r_dec;
        if (w_first || (r_state == IDLE)) begin
            w_dec_base = DEC_UND;
        end
        w_dec_next = w_dec_base;
        if (bus.a != bus.b) begin
            if (!MSB_FIRST || (w_dec_base == DEC_UND)) begin
                w_dec_next = bus.a ? DEC_GT : DEC_LT;
            end
        end
    end

    // Frame sequencing FSM with registered busy/done/g/l/e.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dec   <= DEC_UND;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_g     <= 1'b0;
            r_l     <= 1'b0;
            r_e     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_first) begin
                        r_state <= SHIFT;
                        r_cnt   <= CNT_ONE;
                        r_dec   <= w_dec_next;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_first) begin
                        // Abort silently and treat this pair as bit 0 of a fresh frame.
                        r_cnt <= CNT_ONE;
                        r_dec <= w_dec_next;
                    end else if (w_last) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                        r_dec   <= DEC_UND;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_g     <= (w_dec_next == DEC_GT);
                        r_l     <= (w_dec_next == DEC_LT);
                        r_e     <= (w_dec_next == DEC_UND);
                    end else if (bus.valid) begin
                        r_cnt <= r_cnt + CNT_ONE;
                        r_dec <= w_dec_next;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_dec   <= DEC_UND;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.g    = r_g;
    assign bus.l    = r_l;
    assign bus.e    = r_e;

endmodule

// File: tb/tb_serial_comparator.sv
// Bench for serial_comparator.
// It drives one stimulus stream into an MSB-first instance and an LSB-first instance at the same time.
// A reference model works on whole frames of received bits and turns them into integers.
// The bench checks both instances against the model on every cycle.
// It also checks hand-computed results for a table of directed frames.
module tb_serial_comparator;

    localparam int W = 8;

    logic clk;
    logic rst_n;
    logic s_start, s_valid, s_a, s_b;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    serial_comparator_if bus_m ();
    serial_comparator_if bus_l ();

    assign bus_m.start = s_start;
    assign bus_m.valid = s_valid;
    assign bus_m.a     = s_a;
    assign bus_m.b     = s_b;
    assign bus_l.start = s_start;
    assign bus_l.valid = s_valid;
    assign bus_l.a     = s_a;
    assign bus_l.b     = s_b;

    serial_comparator #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
    serial_comparator #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst_n(rst_n), .bus(bus_l));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // It collects the bits of the open frame. When WIDTH bits have arrived, it builds each operand
    // both ways: first bit as MSB, and first bit as LSB. Then it compares the numbers.
    bit   fa[W];
    bit   fb[W];
    int   nb;
    bit   m_open;
    logic [4:0] m_exp_m;   // {busy, done, g, l, e}
    logic [4:0] m_exp_l;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            nb      = 0;
            m_open  = 0;
            m_exp_m = '0;
            m_exp_l = '0;
        end else begin
            m_exp_m[3] = 1'b0;
            m_exp_l[3] = 1'b0;
            if (s_valid && (s_start || m_open)) begin
                if (s_start) nb = 0;
                fa[nb] = s_a;
                fb[nb] = s_b;
                nb++;
                m_open = 1;
                if (nb == W) begin
                    logic [31:0] am, bm, al, bl;
                    am = 0; bm = 0; al = 0; bl = 0;
                    for (int i = 0; i < W; i++) begin
                        am = (am << 1) | 32'(fa[i]);
                        bm = (bm << 1) | 32'(fb[i]);
                        al = al | (32'(fa[i]) << i);
                        bl = bl | (32'(fb[i]) << i);
                    end
                    m_exp_m[2:0] = {am > bm, am < bm, am == bm};
                    m_exp_l[2:0] = {al > bl, al < bl, al == bl};
                    m_exp_m[3] = 1'b1;
                    m_exp_l[3] = 1'b1;
                    m_open = 0;
                    nb = 0;
                end
            end
            m_exp_m[4] = m_open;
            m_exp_l[4] = m_open;
        end
    end

    // Per-cycle scoreboard, sampled mid-cycle.
    initial forever begin
        @(negedge clk);
        chk("cycle_m", {27'd0, bus_m.busy, bus_m.done, bus_m.g, bus_m.l, bus_m.e}, {27'd0, m_exp_m});
        chk("cycle_l", {27'd0, bus_l.busy, bus_l.done, bus_l.g, bus_l.l, bus_l.e}, {27'd0, m_exp_l});
    end

    // Completion capture for the directed table.
    typedef struct {
        int         cyc;
        logic [2:0] m;
        logic [2:0] l;
    } cap_t;
    cap_t caps[$];

    initial forever begin
        @(negedge clk);
        if (rst_n && bus_m.done) begin
            cap_t c;
            c.cyc = cyc;
            c.m   = {bus_m.g, bus_m.l, bus_m.e};
            c.l   = {bus_l.g, bus_l.l, bus_l.e};
            caps.push_back(c);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         ord;         // 1: send A[7] first, 0: send A[0] first
        bit         b2b;         // first pair goes out with no idle gap
        int         stall_after; // bit index followed by a stall, -1 none
        int         stall_len;
        int         abort_at;    // frame cut before this bit index, W = none
        logic [2:0] exp_m;       // {g,l,e} of the MSB-first instance
        logic [2:0] exp_l;       // {g,l,e} of the LSB-first instance
        int         exp_lat;     // edges from bit-0 accept to last-bit accept
    } vec_t;

    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;
    localparam int NV = 10;

    vec_t tbl[NV];
    int   t0s[NV];

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_start = 1'b0;
        end
    endtask

    task automatic send_frame(input vec_t v, output int t0);
        t0 = 0;
        for (int k = 0; k < W; k++) begin
            if (k == v.abort_at) break;
            @(negedge clk);
            s_start = (k == 0);
            s_valid = 1'b1;
            s_a     = v.ord ? v.a[W-1-k] : v.a[k];
            s_b     = v.ord ? v.b[W-1-k] : v.b[k];
            if (k == 0) t0 = cyc + 1;
            if (k == v.stall_after) begin
                for (int j = 0; j < v.stall_len; j++) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                    s_start = (j == 1);
                    s_a     = 1'($urandom_range(0, 1));
                    s_b     = 1'($urandom_range(0, 1));
                end
            end
        end
    endtask

    initial begin
        int   n_exp;
        int   t0r;
        vec_t rv;
        bit   eqmode;

        tbl[0] = '{8'hA5, 8'hA4, 1'b1, 1'b0, -1, 0, W, GT, GT, 7};
        tbl[1] = '{8'h3C, 8'h3C, 1'b1, 1'b0, -1, 0, W, EQ, EQ, 7};
        tbl[2] = '{8'h00, 8'h80, 1'b1, 1'b1, -1, 0, W, LT, LT, 7};
        tbl[3] = '{8'h01, 8'h80, 1'b0, 1'b0, -1, 0, W, GT, LT, 7};
        tbl[4] = '{8'hFF, 8'h7F, 1'b1, 1'b0,  2, 3, W, GT, GT, 10};
        tbl[5] = '{8'h10, 8'h20, 1'b1, 1'b0, -1, 0, 5, EQ, EQ, 0};
        tbl[6] = '{8'h55, 8'h55, 1'b1, 1'b1, -1, 0, W, EQ, EQ, 7};
        tbl[7] = '{8'h0F, 8'hF0, 1'b1, 1'b0, -1, 0, W, LT, GT, 7};
        tbl[8] = '{8'h00, 8'hFF, 1'b0, 1'b0, -1, 0, W, LT, LT, 7};
        tbl[9] = '{8'h02, 8'h01, 1'b1, 1'b1, -1, 0, W, GT, LT, 7};

        rst_n   = 1'b0;
        s_start = 1'b0;
        s_valid = 1'b0;
        s_a     = 1'b0;
        s_b     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_m", {27'd0, bus_m.busy, bus_m.done, bus_m.g, bus_m.l, bus_m.e}, 32'd0);
        chk("reset_l", {27'd0, bus_l.busy, bus_l.done, bus_l.g, bus_l.l, bus_l.e}, 32'd0);
        #2 rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            if (!tbl[i].b2b) idle(2);
            send_frame(tbl[i], t0s[i]);
        end
        idle(3);

        n_exp = 0;
        for (int i = 0; i < NV; i++) if (tbl[i].abort_at >= W) n_exp++;
        chk("done_count", 32'(caps.size()), 32'(n_exp));
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].abort_at < W) continue;
            if (caps.size() == 0) begin
                chk($sformatf("missing_done[%0d]", i), 32'd0, 32'd1);
            end else begin
                cap_t c;
                c = caps.pop_front();
                chk($sformatf("res_m[%0d]", i), {29'd0, c.m}, {29'd0, tbl[i].exp_m});
                chk($sformatf("res_l[%0d]", i), {29'd0, c.l}, {29'd0, tbl[i].exp_l});
                chk($sformatf("latency[%0d]", i), 32'(c.cyc - t0s[i]), 32'(tbl[i].exp_lat));
            end
        end

        // Reset lands while bit 4 of a frame is on the wire.
        rv = '{8'hC3, 8'h3C, 1'b1, 1'b0, -1, 0, 5, EQ, EQ, 0};
        idle(2);
        send_frame(rv, t0r);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_m", {27'd0, bus_m.busy, bus_m.done, bus_m.g, bus_m.l, bus_m.e}, 32'd0);
        chk("async_rst_l", {27'd0, bus_l.busy, bus_l.done, bus_l.g, bus_l.l, bus_l.e}, 32'd0);
        idle(2);
        #2 rst_n = 1'b1;
        caps.delete();
        rv = '{8'h02, 8'h01, 1'b1, 1'b0, -1, 0, W, GT, LT, 7};
        idle(1);
        send_frame(rv, t0r);
        idle(3);
        chk("post_rst_count", 32'(caps.size()), 32'd1);
        if (caps.size() != 0) begin
            cap_t c;
            c = caps.pop_front();
            chk("post_rst_m", {29'd0, c.m}, {29'd0, GT});
            chk("post_rst_l", {29'd0, c.l}, {29'd0, LT});
            chk("post_rst_lat", 32'(c.cyc - t0r), 32'd7);
        end

        // Random traffic: stalls, restarts and stray starts, checked only by the model.
        eqmode = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if ((n % 250) == 0) eqmode = ~eqmode;
            @(negedge clk);
            s_valid = ($urandom_range(0, 3) != 0);
            s_start = ($urandom_range(0, 13) == 0);
            s_a     = 1'($urandom_range(0, 1));
            s_b     = eqmode ? (s_a ^ ($urandom_range(0, 15) == 0)) : 1'($urandom_range(0, 1));
        end
        idle(W + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Bit-serial N-bit magnitude comparator. It consumes two operands one bit pair per clock, framed by `start`/`valid`, and produces registered greater/less/equal flags with a one-cycle `done` pulse. It sits downstream of serial stimulus/shift sources and is the multi-bit, clocked counterpart of the 1-bit combinational comparator.

## Interface
- `WIDTH`, default 8: operand length in bits; legal range 2–32.
- `MSB_FIRST`, default 1: bit order of the stream. 1 = MSB first, 0 = LSB first.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  marks the first bit pair of a frame; only meaningful with `valid`=1.
- `valid`  in  1  `a`/`b` carry a bit pair this cycle.
- `a`  in  1  serial bit of operand A.
- `b`  in  1  serial bit of operand B.
- `busy`  out  1  a frame is in progress.
- `done`  out  1  one-cycle pulse: `g`/`l`/`e` were just updated.
- `g`  out  1  A > B for the last completed frame.
- `l`  out  1  A < B for the last completed frame.
- `e`  out  1  A == B for the last completed frame.

## Operation
- Reset: state=IDLE, bit counter=0, decision=UNDECIDED, `busy`=0, `done`=0, `g`=`l`=`e`=0. Reset mid-frame discards the frame and gives no `done`.
- States:
  - IDLE → SHIFT on `start`&`valid`. That pair is bit 0 and the counter becomes 1.
  - SHIFT → IDLE when the WIDTH-th pair is accepted.
- Bit acceptance: a pair is accepted only on a cycle with `valid`=1. Cycles with `valid`=0 in SHIFT are stalls: no state change, no timeout.
- `start` with `valid`=0 is ignored in every state.
- Decision register, 2 bits: UNDECIDED / GT / LT.
  - MSB_FIRST=1: the first accepted pair with `a`≠`b` sets GT (a=1) or LT (a=0). Later pairs do not change it.
  - MSB_FIRST=0: every pair with `a`≠`b` overwrites the decision, so the most significant differing bit (the last one received) wins.
  - Pairs with `a`=`b` never change the decision.
- Completion: on the edge that accepts pair WIDTH−1:
  - `g`=(dec==GT), `l`=(dec==LT), `e`=(dec==UNDECIDED). The decision used includes the effect of this last pair.
  - `done`=1 for exactly one cycle.
  - The decision register resets to UNDECIDED.
- Exactly one of `g`/`l`/`e` is 1 after any completed frame. All three are 0 only between reset and the first completion.
- `g`/`l`/`e` hold their values until the next completion. Aborted frames do not touch them.
- Restart: `start`&`valid` while in SHIFT, including on what would be the last bit, aborts the current frame without `done`. That pair becomes bit 0 of a new frame (counter=1, decision from that pair only).
- `busy`=1 exactly while state=SHIFT.
- Counter width is clog2(WIDTH+1). The counter never wraps; it is cleared on completion and on restart.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Latency: with no stalls, the frame's first pair is accepted at edge T0 and the last pair at edge T0+WIDTH−1. `done`, `g`, `l`, `e` are valid in the cycle after that edge, and `busy` falls in that same cycle.
- Stalls stretch the frame 1:1.
- Back-to-back frames: `start`&`valid` is legal in the cycle where `done`=1 (state is IDLE). This gives a sustained throughput of one frame per WIDTH cycles.
- `busy` rises in the cycle after the accepting edge of bit 0.

## Test plan
- WIDTH=8, MSB_FIRST=1, A=0xA5, B=0xA4, 8 consecutive valid cycles → `done` one cycle after bit 7; `g`=1, `l`=0, `e`=0; `busy` high for 7 cycles.
- MSB_FIRST=1, A=0x3C, B=0x3C → `e`=1. Then an immediate back-to-back frame, `start` in the `done` cycle, with A=0x00, B=0x80 → second `done` exactly 8 cycles later with `l`=1; first result stable until then.
- MSB_FIRST=0, A=0x01, B=0x80, sent LSB first → `l`=1 (the later, more significant difference overrides the earlier one).
- A=0xFF, B=0x7F with `valid` deasserted for 3 cycles after bit 2 → `done` 11 cycles after bit 0; `g`=1; `start` pulsed with `valid`=0 during the stall has no effect.
- Frame A=0x10, B=0x20 aborted by `start`&`valid` at bit 5, then new frame A=0x55, B=0x55 → no `done` for the aborted frame; `e`=1 after 8 pairs of the new frame.
- Assert `rst_n`=0 at bit 4 of a frame → `busy`, `done`, `g`, `l`, `e` go to 0 immediately (asynchronously); a following full frame A=0x02, B=0x01 yields `g`=1.
